// File: rtl/fb_pkg.sv
// Shared widths, opcodes, FSM encoding and write payload for the SPI framebuffer writer.
package fb_pkg;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FB_WORDS = 416800;
  localparam int unsigned CNT_W    = 24;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_FILL    = 8'h02;
  localparam logic [7:0] CMD_CLR_ERR = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_CNT0, ST_CNT1, ST_CNT2,
    ST_DHI, ST_DLO, ST_FDHI, ST_FDLO, ST_FILL, ST_ACT, ST_SKIP
  } fb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fb_wr_t;

  // Framebuffer address successor, wrapping after the last word.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(FB_WORDS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampled SPI mode-0 slave front end: synchronizers, byte assembly and status shift-out.
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic [7:0] status,
  output logic       cs_fall_c,
  output logic       cs_rise_c,
  output logic       bit_cnt_nz_c,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       spi_miso
);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] miso_sr_q, miso_sr_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_strobe_q, byte_strobe_d;
  logic       miso_q, miso_d;
  logic       byte0_q, byte0_d;
  logic       cs_n_new, cs_n_old, sck_rise, sck_fall, mosi_s;

  // Edges come from the last two stages; mosi is taken at the same depth as the newer sck stage.
  assign cs_n_new     = cs_sync_q[SYNC_STAGES-2];
  assign cs_n_old     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise     = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
  assign sck_fall     = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-2];
  assign cs_fall_c    = cs_n_old & ~cs_n_new;
  assign cs_rise_c    = ~cs_n_old & cs_n_new;
  assign bit_cnt_nz_c = |bit_cnt_q;

  assign byte_strobe = byte_strobe_q;
  assign rx_byte     = rx_byte_q;
  assign spi_miso    = miso_q;

  always_comb begin
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    byte_strobe_d = 1'b0;
    miso_sr_d     = miso_sr_q;
    miso_d        = miso_q;
    byte0_d       = byte0_q;
    if (cs_n_new) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      miso_d    = 1'b1;
      byte0_d   = 1'b0;
    end else begin
      if (sck_rise) begin
        shift_d   = {shift_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_strobe_d = 1'b1;
          rx_byte_d     = {shift_q, mosi_s};
          byte0_d       = 1'b0;
        end
      end
      // Status MSB is presented at CS fall so it is valid before the first rising edge.
      if (cs_fall_c) begin
        miso_d    = status[7];
        miso_sr_d = status[6:0];
        byte0_d   = 1'b1;
      end else if (sck_fall) begin
        miso_d    = byte0_q ? miso_sr_q[6] : 1'b1;
        miso_sr_d = {miso_sr_q[5:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q     <= '1;
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      byte_strobe_q <= 1'b0;
      miso_sr_q     <= '0;
      miso_q        <= 1'b1;
      byte0_q       <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      byte_strobe_q <= byte_strobe_d;
      miso_sr_q     <= miso_sr_d;
      miso_q        <= miso_d;
      byte0_q       <= byte0_d;
    end
  end

endmodule

// File: rtl/spi_fb_writer.sv
// SPI command decoder producing valid/ready pixel word writes, including hardware fill.
module spi_fb_writer
  import fb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  fb_state_e         state_q, state_d;
  fb_wr_t            wr_q, wr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              is_fill_q, is_fill_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              slot_free, hdr_state;
  logic              cs_fall, cs_rise, bit_cnt_nz, byte_strobe;
  logic [7:0]        rx_byte;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_cs_n     (spi_cs_n),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .status       ({busy_q, overflow_q, frame_err_q, 5'b0}),
    .cs_fall_c    (cs_fall),
    .cs_rise_c    (cs_rise),
    .bit_cnt_nz_c (bit_cnt_nz),
    .byte_strobe  (byte_strobe),
    .rx_byte      (rx_byte),
    .spi_miso     (spi_miso)
  );

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_q.addr;
  assign wr_data   = wr_q.data;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wr_valid_d  = wr_valid_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    fill_data_d = fill_data_q;
    is_fill_d   = is_fill_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    busy_d      = 1'b0;
    // Holding register is free when empty or being accepted this cycle.
    slot_free   = !wr_valid_q || wr_ready;
    hdr_state   = state_q inside {ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_CNT0, ST_CNT1, ST_CNT2,
                                  ST_FDHI, ST_FDLO};
    if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

    if (cs_rise && state_q != ST_IDLE && state_q != ST_FILL) begin
      state_d = ST_IDLE;
      if (bit_cnt_nz || hdr_state) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: if (byte_strobe) begin
          is_fill_d = (rx_byte == CMD_FILL);
          if (rx_byte == CMD_WRITE || rx_byte == CMD_FILL) state_d = ST_ADDR0;
          else if (rx_byte == CMD_CLR_ERR)                 state_d = ST_ACT;
          else                                             state_d = ST_SKIP;
        end
        ST_ADDR0: if (byte_strobe) begin
          addr_d  = {rx_byte[2:0], addr_q[15:0]};
          state_d = ST_ADDR1;
        end
        ST_ADDR1: if (byte_strobe) begin
          addr_d[15:8] = rx_byte;
          state_d      = ST_ADDR2;
        end
        ST_ADDR2: if (byte_strobe) begin
          addr_d[7:0] = rx_byte;
          state_d     = is_fill_q ? ST_CNT0 : ST_DHI;
        end
        ST_CNT0: if (byte_strobe) begin
          cnt_d[23:16] = rx_byte;
          state_d      = ST_CNT1;
        end
        ST_CNT1: if (byte_strobe) begin
          cnt_d[15:8] = rx_byte;
          state_d     = ST_CNT2;
        end
        ST_CNT2: if (byte_strobe) begin
          cnt_d[7:0] = rx_byte;
          state_d    = ST_FDHI;
        end
        ST_DHI: if (byte_strobe) begin
          hi_d    = rx_byte;
          state_d = ST_DLO;
        end
        ST_DLO: if (byte_strobe) begin
          if (slot_free) begin
            wr_valid_d = 1'b1;
            wr_d.addr  = addr_q;
            wr_d.data  = {hi_q, rx_byte};
          end else begin
            overflow_d = 1'b1;
          end
          addr_d  = next_addr(addr_q);
          state_d = ST_DHI;
        end
        ST_FDHI: if (byte_strobe) begin
          hi_d    = rx_byte;
          state_d = ST_FDLO;
        end
        ST_FDLO: if (byte_strobe) begin
          fill_data_d = {hi_q, rx_byte};
          state_d     = ST_FILL;
        end
        ST_FILL: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else if (slot_free) begin
            wr_valid_d = 1'b1;
            wr_d.addr  = addr_q;
            wr_d.data  = fill_data_q;
            addr_d     = next_addr(addr_q);
            cnt_d      = cnt_q - CNT_W'(1);
          end
        end
        ST_ACT: begin
          overflow_d  = 1'b0;
          frame_err_d = 1'b0;
          state_d     = ST_SKIP;
        end
        ST_SKIP: state_d = ST_SKIP;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE) || wr_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_q        <= '0;
      wr_valid_q  <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      fill_data_q <= '0;
      is_fill_q   <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wr_valid_q  <= wr_valid_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      fill_data_q <= fill_data_d;
      is_fill_q   <= is_fill_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

endmodule
